shift_reg_param: RTL and testbench

SHIFT_REG_PARAM -- requirements
Module: shift_reg_param

---
 rtl/shift_reg_param_if.sv | 43 ++++
 rtl/shift_reg_param.sv | 87 ++++++++
 tb/tb_shift_reg_param.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/shift_reg_param_if.sv
// Signal bundle for shift_reg_param: operation controls, serial/parallel data and stage outputs.
// Defining SHIFT_REG_PARAM_ROTATE_EN adds the rot_i rotate request.
interface shift_reg_param_if #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                   en_i;
    logic [1:0]             mode_i;
    logic [WIDTH-1:0]       d_i;
    logic [WIDTH-1:0]       dl_i;
    logic [WIDTH*DEPTH-1:0] pd_i;
`ifdef SHIFT_REG_PARAM_ROTATE_EN
    logic                   rot_i;
`endif
    logic [WIDTH-1:0]       q_o;
    logic [WIDTH-1:0]       ql_o;
    logic [WIDTH*DEPTH-1:0] pq_o;
    logic                   tick_o;
    logic [CNT_W-1:0]       cnt_o;
    logic                   full_o;

`ifdef SHIFT_REG_PARAM_ROTATE_EN
    modport master (
        output en_i, mode_i, d_i, dl_i, pd_i, rot_i,
        input  q_o, ql_o, pq_o, tick_o, cnt_o, full_o
    );
    modport slave (
        input  en_i, mode_i, d_i, dl_i, pd_i, rot_i,
        output q_o, ql_o, pq_o, tick_o, cnt_o, full_o
    );
`else
    modport master (
        output en_i, mode_i, d_i, dl_i, pd_i,
        input  q_o, ql_o, pq_o, tick_o, cnt_o, full_o
    );
    modport slave (
        input  en_i, mode_i, d_i, dl_i, pd_i,
        output q_o, ql_o, pq_o, tick_o, cnt_o, full_o
    );
`endif
endinterface

// File: rtl/shift_reg_param.sv
// Bidirectional shift register with parallel load, enable-gated tick divider and fill counter.
// Optional rotate mode (input rot_i) is compiled in with SHIFT_REG_PARAM_ROTATE_EN.
module shift_reg_param #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4,
    parameter int DIV   = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    shift_reg_param_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_NEAR = CNT_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_FWD  = 2'b01,
        MODE_BWD  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;
    logic [DIV_W-1:0]            div_q;
    logic [CNT_W-1:0]            cnt_q;
    logic                        full_q;
    logic                        tick;
    logic                        rot;
    logic                        shift_op;
    logic [WIDTH-1:0]            fwd_in;
    logic [WIDTH-1:0]            bwd_in;
    mode_e                       mode;

    assign mode = mode_e'(bus.mode_i);

`ifdef SHIFT_REG_PARAM_ROTATE_EN
    assign rot = bus.rot_i;
`else
    assign rot = 1'b0;
`endif

    // Reset gates the tick so nothing executes while the register is held clear.
    assign tick     = rst_i & bus.en_i & (div_q == DIV_LAST);
    assign shift_op = (mode == MODE_FWD) || (mode == MODE_BWD);
    assign fwd_in   = rot ? stage_q[DEPTH-1] : bus.d_i;
    assign bwd_in   = rot ? stage_q[0]       : bus.dl_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            div_q <= '0;
        end else if (bus.en_i) begin
            div_q <= (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stage_q <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
        end else if (tick) begin
            case (mode)
                MODE_FWD:  stage_q <= {stage_q[DEPTH-2:0], fwd_in};
                MODE_BWD:  stage_q <= {bwd_in, stage_q[DEPTH-1:1]};
                MODE_LOAD: stage_q <= bus.pd_i;
                default:   stage_q <= stage_q;
            endcase
            // full_q is kept as its own flop so full_o stays a registered output.
            if (mode == MODE_LOAD) begin
                cnt_q  <= CNT_FULL;
                full_q <= 1'b1;
            end else if (shift_op && !rot && !full_q) begin
                cnt_q  <= cnt_q + CNT_W'(1);
                full_q <= (cnt_q == CNT_NEAR);
            end
        end
    end

    assign bus.q_o    = stage_q[DEPTH-1];
    assign bus.ql_o   = stage_q[0];
    assign bus.pq_o   = stage_q;
    assign bus.tick_o = tick;
    assign bus.cnt_o  = cnt_q;
    assign bus.full_o = full_q;
endmodule

// File: tb/tb_shift_reg_param.sv
// Directed bench for shift_reg_param: three instances (4x1 DIV=1, 4x1 DIV=3, 2x8 DIV=1) with a scoreboard.
module tb_shift_reg_param;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    shift_reg_param_if #(.WIDTH(1), .DEPTH(4)) ifa ();
    shift_reg_param_if #(.WIDTH(1), .DEPTH(4)) ifb ();
    shift_reg_param_if #(.WIDTH(8), .DEPTH(2)) ifc ();

    shift_reg_param #(.WIDTH(1), .DEPTH(4), .DIV(1)) dut_a (.clk_i(clk), .rst_i(rst_n), .bus(ifa));
    shift_reg_param #(.WIDTH(1), .DEPTH(4), .DIV(3)) dut_b (.clk_i(clk), .rst_i(rst_n), .bus(ifb));
    shift_reg_param #(.WIDTH(8), .DEPTH(2), .DIV(1)) dut_c (.clk_i(clk), .rst_i(rst_n), .bus(ifc));

    int checks = 0;
    int failures = 0;
    string       sb_tag[$];
    logic [31:0] sb_exp[$];

    logic [3:0] ma_st, mb_st;
    int         ma_cnt, mb_cnt, mb_div, b_ticks, b_before, first_tick;
    logic [3:0] seq;

    task automatic push(input string tag, input logic [31:0] e);
        sb_tag.push_back(tag);
        sb_exp.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        string       tag;
        logic [31:0] e;
        checks++;
        if (sb_exp.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%0h", obs);
            return;
        end
        tag = sb_tag.pop_front();
        e   = sb_exp.pop_front();
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
        end
    endtask

    function automatic logic [3:0] nxt_st(input logic [3:0] st, input logic [1:0] mode,
                                          input logic d, input logic dl, input logic [3:0] pd);
        case (mode)
            2'b01:   return {st[2:0], d};
            2'b10:   return {dl, st[3:1]};
            2'b11:   return pd;
            default: return st;
        endcase
    endfunction

    function automatic int nxt_cnt(input int c, input logic [1:0] mode);
        if (mode == 2'b11) return 4;
        if (mode == 2'b00) return c;
        return (c < 4) ? c + 1 : 4;
    endfunction

    // Called #1 after a rising edge; returns #1 after the next rising edge.
    task automatic a_step(input logic en, input logic [1:0] mode, input logic d,
                          input logic dl, input logic [3:0] pd);
        ifa.en_i = en; ifa.mode_i = mode; ifa.d_i = d; ifa.dl_i = dl; ifa.pd_i = pd;
        #1;
        push("a_tick", 32'(en));
        pop_check(32'(ifa.tick_o));
        if (en) begin
            ma_st  = nxt_st(ma_st, mode, d, dl, pd);
            ma_cnt = nxt_cnt(ma_cnt, mode);
        end
        push("a_pq", 32'(ma_st));
        push("a_cnt", 32'(ma_cnt));
        push("a_full", 32'(ma_cnt == 4));
        push("a_q", 32'(ma_st[3]));
        push("a_ql", 32'(ma_st[0]));
        @(posedge clk); #1;
        pop_check(32'(ifa.pq_o));
        pop_check(32'(ifa.cnt_o));
        pop_check(32'(ifa.full_o));
        pop_check(32'(ifa.q_o));
        pop_check(32'(ifa.ql_o));
    endtask

    task automatic b_cycle(input logic en, input logic [1:0] mode, input logic d, input logic [3:0] pd);
        logic exp_tick;
        ifb.en_i = en; ifb.mode_i = mode; ifb.d_i = d; ifb.dl_i = 1'b0; ifb.pd_i = pd;
        #1;
        exp_tick = en && (mb_div == 2);
        push("b_tick", 32'(exp_tick));
        pop_check(32'(ifb.tick_o));
        if (en) mb_div = (mb_div == 2) ? 0 : mb_div + 1;
        if (exp_tick) begin
            mb_st  = nxt_st(mb_st, mode, d, 1'b0, pd);
            mb_cnt = nxt_cnt(mb_cnt, mode);
            b_ticks++;
        end
        push("b_pq", 32'(mb_st));
        push("b_cnt", 32'(mb_cnt));
        @(posedge clk); #1;
        pop_check(32'(ifb.pq_o));
        pop_check(32'(ifb.cnt_o));
    endtask

    task automatic c_step(input logic [7:0] d, input logic [15:0] e_pq, input int e_cnt, input logic e_full);
        ifc.en_i = 1'b1; ifc.mode_i = 2'b01; ifc.d_i = d; ifc.dl_i = 8'h00; ifc.pd_i = 16'h0000;
        push("c_pq", 32'(e_pq));
        push("c_cnt", 32'(e_cnt));
        push("c_full", 32'(e_full));
        @(posedge clk); #1;
        pop_check(32'(ifc.pq_o));
        pop_check(32'(ifc.cnt_o));
        pop_check(32'(ifc.full_o));
    endtask

    initial begin
        ifa.en_i = 1'b1; ifa.mode_i = 2'b01; ifa.d_i = 1'b1; ifa.dl_i = 1'b0; ifa.pd_i = '0;
        ifb.en_i = 1'b0; ifb.mode_i = 2'b00; ifb.d_i = 1'b0; ifb.dl_i = 1'b0; ifb.pd_i = '0;
        ifc.en_i = 1'b0; ifc.mode_i = 2'b00; ifc.d_i = '0;   ifc.dl_i = '0;   ifc.pd_i = '0;
        rst_n = 1'b0;
        #2;
        // Reset state before any clock edge; A has en_i=1 so tick must still be gated.
        push("rst_a_tick", 0); pop_check(32'(ifa.tick_o));
        push("rst_a_pq", 0);   pop_check(32'(ifa.pq_o));
        push("rst_a_cnt", 0);  pop_check(32'(ifa.cnt_o));
        push("rst_a_full", 0); pop_check(32'(ifa.full_o));
        push("rst_c_pq", 0);   pop_check(32'(ifc.pq_o));
        ifa.en_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        ma_st = '0; ma_cnt = 0;
        seq = '0;
        for (int i = 0; i < 7; i++) begin
            logic dv;
            dv = (i == 0 || i == 2 || i == 3);
            a_step(1'b1, 2'b01, dv, 1'b0, 4'h0);
            if (i >= 3) seq = {seq[2:0], ifa.q_o};
        end
        push("a_q_ticks4to7", 32'h000B); pop_check(32'(seq));

        a_step(1'b0, 2'b01, 1'b1, 1'b0, 4'h0);
        a_step(1'b1, 2'b00, 1'b1, 1'b1, 4'hF);

        a_step(1'b1, 2'b11, 1'b0, 1'b0, 4'b1010);
        seq = '0;
        for (int i = 0; i < 4; i++) begin
            seq = {seq[2:0], ifa.ql_o};
            a_step(1'b1, 2'b10, 1'b0, 1'b0, 4'h0);
        end
        push("a_ql_before_bwd", 32'h0005); pop_check(32'(seq));
        push("a_ql_after_bwd", 0);         pop_check(32'(ifa.ql_o));
        push("a_cnt_after_bwd", 4);        pop_check(32'(ifa.cnt_o));
        ifa.en_i = 1'b0;

        c_step(8'hA5, 16'h00A5, 1, 1'b0);
        c_step(8'h3C, 16'hA53C, 2, 1'b1);
        c_step(8'hFF, 16'h3CFF, 2, 1'b1);
        ifc.en_i = 1'b0;

        mb_st = '0; mb_cnt = 0; mb_div = 0; b_ticks = 0;
        for (int i = 0; i < 6; i++) b_cycle(1'b1, 2'b01, 1'b1, 4'h0);
        push("b_ticks_in_6", 2); pop_check(32'(b_ticks));
        for (int i = 0; i < 5; i++) b_cycle(1'b0, 2'b01, 1'b1, 4'h0);
        push("b_ticks_frozen", 2); pop_check(32'(b_ticks));
        b_cycle(1'b1, 2'b11, 1'b0, 4'hF);
        b_cycle(1'b1, 2'b11, 1'b0, 4'hF);
        b_cycle(1'b1, 2'b01, 1'b0, 4'hF);
        push("b_mode_between_ticks", 32'h0006); pop_check(32'(ifb.pq_o));

        // Divider now at 1 with nonzero stages; reset lands mid-cycle.
        b_cycle(1'b1, 2'b01, 1'b1, 4'h0);
        #2;
        rst_n = 1'b0;
        #1;
        push("b_rst_pq", 0);   pop_check(32'(ifb.pq_o));
        push("b_rst_cnt", 0);  pop_check(32'(ifb.cnt_o));
        push("b_rst_full", 0); pop_check(32'(ifb.full_o));
        push("b_rst_q", 0);    pop_check(32'(ifb.q_o));
        push("b_rst_tick", 0); pop_check(32'(ifb.tick_o));
        mb_st = '0; mb_cnt = 0; mb_div = 0;
        ifb.en_i = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        first_tick = 0;
        for (int i = 1; i <= 6; i++) begin
            if (first_tick == 0) begin
                b_before = b_ticks;
                b_cycle(1'b1, 2'b01, 1'b1, 4'h0);
                if (b_ticks != b_before) first_tick = i;
            end
        end
        push("b_first_tick_after_rst", 3); pop_check(32'(first_tick));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
